// File: rtl/fp_pow_seq.sv
// Sequential FP32 integer power: A^sel by square-and-multiply over 5 exponent bits.
// One shared combinational FP32 multiplier, fixed 10-cycle latency.
module fp_pow_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [4:0]  sel,
  output logic [31:0] ansS,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] ONE = 32'h3F80_0000;

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  state_t      state, stateNext;
  logic [2:0]  k;
  logic [31:0] acc, aLat, opB, prod;
  logic [4:0]  selLat;

  logic [47:0]        p;
  logic [22:0]        mant;
  logic [23:0]        mr;
  logic               g, st, sgn;
  logic signed [9:0]  e;

  assign busy = (state == SQR) || (state == MUL);
  assign done = (state == DONE);

  // Shared multiplier: acc*acc in SQR, acc*A in MUL
  always_comb begin
    opB  = (state == MUL) ? aLat : acc;
    sgn  = acc[31] ^ opB[31];
    p    = 48'({1'b1, acc[22:0]}) * 48'({1'b1, opB[22:0]});
    e    = $signed({2'b00, acc[30:23]}) + $signed({2'b00, opB[30:23]}) - 10'sd127;
    mant = p[45:23];
    g    = p[22];
    st   = |p[21:0];
    if (p[47]) begin
      mant = p[46:24];
      g    = p[23];
      st   = |p[22:0];
      e    = e + 10'sd1;
    end
    mr = {1'b0, mant} + {23'd0, g & (st | mant[0])};
    if (mr[23]) e = e + 10'sd1;
    prod = {sgn, e[7:0], mr[22:0]};
    if (e <= 10'sd0)
      prod = {sgn, 31'd0};
    else if (e >= 10'sd255)
      prod = {sgn, 8'hFF, 23'd0};
    if (acc[30:23] == 8'h00 || opB[30:23] == 8'h00)
      prod = {sgn, 31'd0};
    if (acc[30:23] == 8'hFF || opB[30:23] == 8'hFF)
      prod = 32'h7FFF_FFFF;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE, DONE: if (start) stateNext = SQR;
      SQR:        stateNext = MUL;
      MUL:        stateNext = (k == 3'd0) ? DONE : SQR;
      default:    stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      k      <= 3'd0;
      acc    <= 32'd0;
      aLat   <= 32'd0;
      selLat <= 5'd0;
      ansS   <= 32'd0;
    end else begin
      state <= stateNext;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            aLat   <= A;
            selLat <= sel;
            acc    <= ONE;
            k      <= 3'd4;
          end
        end
        SQR: acc <= prod;
        MUL: begin
          if (selLat[k]) acc <= prod;
          if (k == 3'd0)
            ansS <= selLat[k] ? prod : acc;
          else
            k <= k - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_pow_seq.sv
// Scoreboard bench for fp_pow_seq: directed vectors, expected results queued
// at issue time and checked by a monitor on each rising done.
module tb_fp_pow_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [4:0]  sel;
  logic [31:0] ansS;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int issued = 0;
  int seen = 0;
  logic [31:0] expQ[$];
  logic prevDone = 1'b0;

  fp_pow_seq dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .sel(sel),
    .ansS(ansS), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: one result per rising done
  always @(negedge clk) begin
    if (done === 1'b1 && prevDone === 1'b0) begin
      seen++;
      tests++;
      if (expQ.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got %08h expected no result", ansS);
      end else begin
        logic [31:0] e;
        e = expQ.pop_front();
        if (ansS !== e) begin
          fails++;
          $display("FAIL result: got %08h expected %08h", ansS, e);
        end
      end
    end
    prevDone = done;
  end

  // Issue one op and check the fixed 10-cycle latency
  task automatic runOp(input string name, input logic [31:0] a,
                       input logic [4:0] s, input logic [31:0] exp);
    @(negedge clk);
    A = a; sel = s; start = 1'b1;
    expQ.push_back(exp);
    issued++;
    @(posedge clk);
    #1 start = 1'b0;
    check({name, "_busy_T1"}, {31'd0, busy}, 32'd1);
    repeat (9) @(posedge clk);
    #1 check({name, "_busy_T9"}, {30'd0, busy, done}, 32'd2);
    @(posedge clk);
    #1 check({name, "_done_T10"}, {30'd0, busy, done}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = 32'd0; sel = 5'd0;
    #1;
    check("reset_ans", ansS, 32'd0);
    check("reset_flags", {30'd0, busy, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    runOp("pow2_3",   32'h4000_0000, 5'd3,  32'h4100_0000);
    runOp("pow15_2",  32'h3FC0_0000, 5'd2,  32'h4010_0000);
    runOp("neg2_5",   32'hC000_0000, 5'd5,  32'hC200_0000);
    runOp("pi_0",     32'h4049_0FDB, 5'd0,  32'h3F80_0000);
    runOp("ovf",      32'h4780_0000, 5'd8,  32'h7F80_0000);
    runOp("unf",      32'h3780_0000, 5'd8,  32'h0000_0000);
    runOp("pow3_2",   32'h4040_0000, 5'd2,  32'h4110_0000);
    runOp("one_31",   32'h3F80_0000, 5'd31, 32'h3F80_0000);
    runOp("half_4",   32'h3F00_0000, 5'd4,  32'h3D80_0000);
    runOp("neg15_3",  32'hBFC0_0000, 5'd3,  32'hC058_0000);
    runOp("sticky",   32'h3F80_0001, 5'd2,  32'h3F80_0002);
    runOp("rnd_dn",   32'h3FFF_FFFF, 5'd2,  32'h407F_FFFE);
    runOp("rnd_up",   32'h3FC0_0001, 5'd2,  32'h4010_0002);

    // start held through busy while operands change
    @(negedge clk);
    A = 32'h4000_0000; sel = 5'd3; start = 1'b1;
    expQ.push_back(32'h4100_0000);
    issued++;
    @(posedge clk);
    repeat (2) @(negedge clk);
    A = 32'h4040_0000; sel = 5'd31;
    repeat (6) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("held_flags", {30'd0, busy, done}, 32'd1);
    check("held_ans", ansS, 32'h4100_0000);

    // async reset mid-run
    @(negedge clk);
    A = 32'h4000_0000; sel = 5'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_flags", {30'd0, busy, done}, 32'd0);
    check("rst_mid_ans", ansS, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    runOp("after_rst", 32'h4000_0000, 5'd4, 32'h4180_0000);

    repeat (15) @(negedge clk);
    check("queue_empty", expQ.size(), 32'd0);
    check("done_count", seen, issued);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
